booth_seq_mul: RTL and testbench

Parametrised, iterative signed Booth multiplier for the mantissa-multiply path of the floating-point ALU. It replaces the single-step, fixed 25-bit Booth stage. It accepts two two's-complement operands under a start/done handshake and iterates one Booth step per clock. It returns the full-width product together with a sideband tag (sign/exponent) captured at start, so the next normalise stage receives matched data.

---
 rtl/booth_seq_mul.sv | 175 +++++++++++++++++
 tb/tb_booth_seq_mul.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// -----------------------------------------------------------------------------
// booth_seq_mul
//   Iterative signed Booth multiplier for the FP mantissa-multiply path.
//   It does one Booth step per clock and returns the full 2*WIDTH-bit signed
//   product. A sideband tag is captured at start and released with the
//   product, so the normalise stage receives matched data.
//
//   Build option: define BOOTH_RADIX4_EN to select modified Booth radix-4,
//   which takes ceil(WIDTH/2) steps. Without it the multiplier is radix-2 and
//   takes WIDTH steps. The product value and the handshake are the same in
//   both builds.
//
// Parameters
//   WIDTH         operand width, two's complement (4..64)
//   TAG_W         sideband width, passed through unchanged
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         request, sampled only in IDLE or DONE
//   multiplicand  signed operand M
//   multiplier    signed operand Q
//   tag_i         sideband captured with the operands
//   busy          high while Booth steps are running
//   done          one-cycle pulse; product/tag_o are valid from this cycle
//   product       signed M*Q, held until the next result
//   tag_o         tag captured at the accepted start, held with product
// -----------------------------------------------------------------------------
module booth_seq_mul #(
    parameter int WIDTH = 25,
    parameter int TAG_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     tag_o
);

`ifdef BOOTH_RADIX4_EN
    localparam int STEPS = (WIDTH + 1) / 2;
    localparam int QW    = 2 * STEPS;      // Q is sign-extended to an even width
`else
    localparam int STEPS = WIDTH;
    localparam int QW    = WIDTH;
`endif
    localparam int AW = WIDTH + 2;         // the two guard bits absorb +/-2M and -2^(W-1)
    localparam int CW = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    // Holds the one idle cycle of the zero shortcut, so that done follows
    // the edge after the accepting edge without asserting busy.
    localparam logic [1:0] S_ZERO = 2'd3;

    logic [1:0]       state;
    logic [AW-1:0]    m_reg;
    logic [AW-1:0]    acc;
    logic [QW-1:0]    q_reg;
    logic             q_m1;
    logic [CW-1:0]    count;
    logic [TAG_W-1:0] tag_reg;

    logic [QW-1:0]    q_load;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    acc_sum;
    logic [AW-1:0]    acc_nxt;
    logic [QW-1:0]    q_nxt;
    logic             q_m1_nxt;
    logic             accept;
    logic             zero_op;
    logic             last_step;

    generate
        if (QW > WIDTH) begin : g_qext
            assign q_load = {multiplier[WIDTH-1], multiplier};
        end else begin : g_qeq
            assign q_load = multiplier;
        end
    endgenerate

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign zero_op   = (multiplicand == '0) || (multiplier == '0);
    assign last_step = (count == CW'(STEPS - 1));

`ifdef BOOTH_RADIX4_EN
    logic [AW-1:0] m2;
    assign m2 = {m_reg[AW-2:0], 1'b0};

    always_comb begin
        addend = '0;
        unique case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: addend = m_reg;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m_reg;
            default:        addend = '0;
        endcase
        acc_sum  = acc + addend;
        acc_nxt  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        q_nxt    = {acc_sum[1:0], q_reg[QW-1:2]};
        q_m1_nxt = q_reg[1];
    end
`else
    always_comb begin
        addend = '0;
        unique case ({q_reg[0], q_m1})
            2'b01:   addend = m_reg;
            2'b10:   addend = -m_reg;
            default: addend = '0;
        endcase
        acc_sum  = acc + addend;
        acc_nxt  = {acc_sum[AW-1], acc_sum[AW-1:1]};
        q_nxt    = {acc_sum[0], q_reg[QW-1:1]};
        q_m1_nxt = q_reg[0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            m_reg   <= '0;
            acc     <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            tag_reg <= '0;
            product <= '0;
            tag_o   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        m_reg   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                        acc     <= '0;
                        q_reg   <= q_load;
                        q_m1    <= 1'b0;
                        count   <= '0;
                        tag_reg <= tag_i;
                        state   <= zero_op ? S_ZERO : S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    q_reg <= q_nxt;
                    q_m1  <= q_m1_nxt;
                    count <= count + 1'b1;
                    if (last_step) begin
                        state   <= S_DONE;
                        // Low 2*WIDTH bits of {A, Q} after the final shift.
                        product <= {acc_nxt[2*WIDTH-QW-1:0], q_nxt};
                        tag_o   <= tag_reg;
                    end
                end
                S_ZERO: begin
                    state   <= S_DONE;
                    product <= '0;
                    tag_o   <= tag_reg;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_booth_seq_mul.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mul
//   Directed self-checking bench for booth_seq_mul (WIDTH=25, TAG_W=10).
//   Expected products come from the bench's own 64-bit signed arithmetic and
//   are queued at start, then popped when done is seen.
// -----------------------------------------------------------------------------
module tb_booth_seq_mul;

    localparam int W  = 25;
    localparam int TW = 10;
`ifdef BOOTH_RADIX4_EN
    localparam int N = (W + 1) / 2;
`else
    localparam int N = W;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplier;
    logic [TW-1:0]   tag_in;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;
    logic [TW-1:0]   tag_out;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc, bcnt, dcnt, ovl;

    always #5 clk = ~clk;

    booth_seq_mul #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(mcand), .multiplier(mplier), .tag_i(tag_in),
        .busy(busy), .done(done), .product(product), .tag_o(tag_out)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy) bcnt++;
        if (done) dcnt++;
        if (busy && done) ovl++;
    endtask

    task automatic push_exp(input longint m, input longint q, input logic [TW-1:0] t);
        exp_t   x;
        longint p;
        p   = m * q;
        x.p = p[2*W-1:0];
        x.t = t;
        sb.push_back(x);
    endtask

    task automatic clr_counts();
        cyc  = 0;
        bcnt = busy ? 1 : 0;
        dcnt = done ? 1 : 0;
        ovl  = 0;
    endtask

    // Drives one request; returns just after the accepting edge E0.
    task automatic start_op(input longint m, input longint q, input logic [TW-1:0] t);
        @(negedge clk);
        mcand  = m[W-1:0];
        mplier = q[W-1:0];
        tag_in = t;
        start  = 1'b1;
        push_exp(m, q, t);
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        tag_in = TW'($urandom);
        clr_counts();
    endtask

    task automatic wait_result(input string nm, input int lat, input int busy_exp, input bit pulse);
        while (!done && cyc < 200) tick();
        chk({nm, "_latency"}, 64'(cyc), 64'(lat));
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(busy_exp));
        chk({nm, "_busy_done_overlap"}, 64'(ovl), 64'd0);
        chk({nm, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({nm, "_product"}, 64'(product), 64'(e.p));
            chk({nm, "_tag"}, 64'(tag_out), 64'(e.t));
        end
        if (pulse) begin
            tick();
            chk({nm, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        longint hold_p;
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        tag_in = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // basic product
        start_op(3, 5, 10'h155);
        wait_result("m3q5", N, N, 1'b1);

        // sign corner cases
        start_op(-1, -16777216, 10'h0F0);
        wait_result("neg1_min", N, N, 1'b1);
        start_op(-16777216, -16777216, 10'h30F);
        wait_result("min_min", N, N, 1'b1);
        chk("min_min_bit49", 64'(product[2*W-1]), 64'd0);
        start_op(-16777216, 16777215, 10'h001);
        wait_result("min_max", N, N, 1'b1);

        // zero shortcut, both operand positions
        start_op(0, 12345, 10'h2A5);
        wait_result("zero_m", 1, 0, 1'b1);
        start_op(-77, 0, 10'h11B);
        wait_result("zero_q", 1, 0, 1'b1);

        // start during RUN is ignored
        start_op(100, -3, 10'h0AA);
        repeat (4) tick();
        @(negedge clk);
        start  = 1'b1;
        mcand  = 7;
        mplier = 7;
        tag_in = 10'h3FF;
        tick();
        start  = 1'b0;
        wait_result("ignored", N, N, 1'b1);
        repeat (N + 5) tick();
        chk("ignored_single_done", 64'(dcnt), 64'd1);
        hold_p = -300;
        chk("ignored_hold", 64'(product), 64'(hold_p[2*W-1:0]));

        // reset mid-RUN aborts
        start_op(11, 13, 10'h099);
        while (cyc < 10) tick();
        reset = 1'b1;
        #1;
        chk("midrst_product", 64'(product), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_tag", 64'(tag_out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        e = sb.pop_back();
        clr_counts();
        repeat (30) tick();
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        chk("midrst_product_held", 64'(product), 64'd0);
        start_op(-6, 9, 10'h1E1);
        wait_result("after_rst", N, N, 1'b1);

        // back-to-back with start held through DONE
        @(negedge clk);
        mcand  = W'(-123);
        mplier = W'(456);
        tag_in = 10'h1C3;
        start  = 1'b1;
        push_exp(-123, 456, 10'h1C3);
        @(posedge clk);
        #1;
        clr_counts();
        mcand  = W'(-16777216);
        mplier = W'(-16777216);
        tag_in = 10'h2B7;
        push_exp(-16777216, -16777216, 10'h2B7);
        wait_result("b2b_first", N, N, 1'b0);
        cyc  = 0;
        bcnt = 0;
        dcnt = 0;
        ovl  = 0;
        tick();
        start = 1'b0;
        wait_result("b2b_second", N + 1, N, 1'b1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
